// File: rtl/serial_odev_pkg.sv
// Shared definitions for the serial output device: transmit FSM encoding and
// status byte bit positions.
package serial_odev_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } tx_state_e;

  localparam int unsigned StatBusy = 0;
  localparam int unsigned StatFull = 1;
  localparam int unsigned StatOvr  = 2;

endpackage

// File: rtl/byte_fifo.sv
// Small byte FIFO with registered pointers; a push while full is accepted only
// when a pop happens on the same edge.
module byte_fifo #(
  parameter int unsigned DepthLog2 = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);

  localparam int unsigned Depth = 1 << DepthLog2;
  localparam logic [DepthLog2:0] DepthCnt = (DepthLog2 + 1)'(Depth);

  logic [7:0]           mem_q [Depth];
  logic [DepthLog2-1:0] wr_ptr_q;
  logic [DepthLog2-1:0] rd_ptr_q;
  logic [DepthLog2:0]   count_q;
  logic                 do_push;
  logic                 do_pop;

  assign full    = (count_q == DepthCnt);
  assign empty   = (count_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/serial_odev.sv
// Byte-wide serial output device: queues CPU writes and shifts them out as 8N1,
// LSB first, with a pollable status byte.
module serial_odev
  import serial_odev_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT    = 16,
  parameter int unsigned FIFO_DEPTH_LOG2 = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_b,
  input  logic [7:0] data_i,
  input  logic       stat_rd_b,
  output logic [7:0] status_o,
  output logic       tx
);

  tx_state_e  state_q;
  logic [7:0] baud_q;
  logic [2:0] bit_q;
  logic [7:0] shift_q;
  logic       tx_q;
  logic       ovr_q;

  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_rdata;
  logic       baud_done;
  logic       pop;
  logic       push_req;
  logic       ovr_set;
  logic       busy;

  assign baud_done = (baud_q == 8'(CLKS_PER_BIT - 1));
  // The last stop-bit edge also pops so back-to-back frames have no gap.
  assign pop       = ~fifo_empty & ((state_q == StIdle) | ((state_q == StStop) & baud_done));
  assign push_req  = ~wr_b;
  assign ovr_set   = push_req & fifo_full & ~pop;
  assign busy      = (state_q != StIdle) | ~fifo_empty;

  always_comb begin
    status_o           = 8'h00;
    status_o[StatBusy] = busy;
    status_o[StatFull] = fifo_full;
    status_o[StatOvr]  = ovr_q;
  end

  assign tx = tx_q;

  byte_fifo #(
    .DepthLog2(FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push_req),
    .pop  (pop),
    .wdata(data_i),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ovr_q   <= 1'b0;
    end else begin
      if (ovr_set) begin
        ovr_q <= 1'b1;
      end else if (!stat_rd_b) begin
        ovr_q <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_q <= fifo_rdata;
            baud_q  <= '0;
            tx_q    <= 1'b0;
            state_q <= StStart;
          end
        end
        StStart: begin
          if (baud_done) begin
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= StData;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        StData: begin
          if (baud_done) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= StStop;
            end else begin
              bit_q   <= bit_q + 1'b1;
              shift_q <= shift_q >> 1;
              tx_q    <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        StStop: begin
          if (baud_done) begin
            baud_q <= '0;
            if (pop) begin
              shift_q <= fifo_rdata;
              tx_q    <= 1'b0;
              state_q <= StStart;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_odev.sv
// Self-checking bench for serial_odev: a serial receiver model decodes tx and
// compares each frame against a queue of bytes expected to be sent.
module tb_serial_odev;

  localparam int unsigned Cpb = 4;
  localparam int unsigned FrameLen = 10 * Cpb;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_b = 1'b1;
  logic       stat_rd_b = 1'b1;
  logic [7:0] data_i = 8'h00;
  logic [7:0] status_o;
  logic       tx;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rx_frames = 0;
  logic [7:0] exp_q[$];
  int start_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_odev #(
    .CLKS_PER_BIT(Cpb),
    .FIFO_DEPTH_LOG2(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_b     (wr_b),
    .data_i   (data_i),
    .stat_rd_b(stat_rd_b),
    .status_o (status_o),
    .tx       (tx)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one write strobe for the next rising edge; keep=1 queues it for the receiver.
  task automatic put(input logic [7:0] b, input bit keep);
    wr_b = 1'b0;
    data_i = b;
    if (keep) exp_q.push_back(b);
    @(negedge clk);
    wr_b = 1'b1;
  endtask

  // Receiver model: samples each bit mid-cell, drops frames cut by reset.
  initial begin
    logic [9:0] bits;
    logic [7:0] e;
    bit abort;
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        start_q.push_back(cyc);
        abort = 1'b0;
        bits = '0;
        for (int c = 1; c <= int'(9 * Cpb + Cpb / 2); c++) begin
          @(negedge clk);
          if (rst) abort = 1'b1;
          if (c % Cpb == Cpb / 2) bits[c / Cpb] = tx;
        end
        if (!abort) begin
          rx_frames++;
          check("rx_start", 32'(bits[0]), 32'd0);
          check("rx_stop", 32'(bits[9]), 32'd1);
          if (exp_q.size() == 0) begin
            check("rx_unexpected", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("rx_data", 32'(bits[8:1]), 32'(e));
          end
        end
      end
    end
  end

  initial begin
    logic [9:0] frame;
    bit bad;
    int frames_before;

    // Reset and idle
    repeat (3) @(negedge clk);
    check("rst_status", 32'(status_o), 32'h00);
    check("rst_tx", 32'(tx), 32'd1);
    rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (status_o !== 8'h00 || tx !== 1'b1) bad = 1'b1;
    end
    check("idle_quiet", 32'(bad), 32'd0);

    // Single byte, cycle-exact waveform
    frame = {1'b1, 8'hA5, 1'b0};
    put(8'hA5, 1'b1);
    check("single_tx_not_yet", 32'(tx), 32'd1);
    check("single_busy_early", 32'(status_o), 32'h01);
    bad = 1'b0;
    for (int i = 0; i < int'(FrameLen); i++) begin
      @(negedge clk);
      if (tx !== frame[i / Cpb]) begin
        bad = 1'b1;
        $display("FAIL single_bit: cycle %0d got %0b expected %0b", i, tx, frame[i / Cpb]);
      end
      if (status_o[0] !== 1'b1) bad = 1'b1;
    end
    check("single_wave", 32'(bad), 32'd0);
    @(negedge clk);
    check("single_done_status", 32'(status_o), 32'h00);
    repeat (5) @(negedge clk);
    check("single_rx_frames", 32'(rx_frames), 32'd1);

    // Back-to-back frames
    start_q.delete();
    put(8'h01, 1'b1);
    put(8'h02, 1'b1);
    put(8'h03, 1'b1);
    bad = 1'b0;
    for (int i = 0; i < int'(3 * FrameLen + 10); i++) begin
      @(negedge clk);
      if (status_o[1] !== 1'b0) bad = 1'b1;
    end
    check("b2b_never_full", 32'(bad), 32'd0);
    check("b2b_starts", 32'(start_q.size()), 32'd3);
    if (start_q.size() == 3) begin
      check("b2b_gap1", 32'(start_q[1] - start_q[0]), 32'(FrameLen));
      check("b2b_gap2", 32'(start_q[2] - start_q[1]), 32'(FrameLen));
    end
    check("b2b_drained", 32'(exp_q.size()), 32'd0);

    // Overrun: six writes, fifth fills, sixth dropped
    put(8'h10, 1'b1);
    put(8'h20, 1'b1);
    put(8'h30, 1'b1);
    put(8'h40, 1'b1);
    put(8'h50, 1'b1);
    put(8'h60, 1'b0);
    check("ovr_status", 32'(status_o), 32'h07);
    stat_rd_b = 1'b0;
    @(negedge clk);
    stat_rd_b = 1'b1;
    check("ovr_cleared", 32'(status_o), 32'h03);
    repeat (5 * FrameLen + 10) @(negedge clk);
    check("ovr_drained", 32'(exp_q.size()), 32'd0);
    check("ovr_idle_status", 32'(status_o), 32'h00);

    // Full with simultaneous pop at the end of the first frame
    put(8'hC3, 1'b1);
    put(8'h11, 1'b1);
    put(8'h22, 1'b1);
    put(8'h44, 1'b1);
    put(8'h88, 1'b1);
    repeat (FrameLen - 4) @(negedge clk);
    check("fp_full_before", 32'(status_o), 32'h03);
    put(8'h5A, 1'b1);
    check("fp_after_push", 32'(status_o), 32'h03);
    check("fp_no_ovr", 32'(status_o[2]), 32'd0);
    repeat (5 * FrameLen + 10) @(negedge clk);
    check("fp_drained", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset during data bit 3 of 8'h33 (bit 3 is 0)
    put(8'h33, 1'b0);
    repeat (18) @(negedge clk);
    check("ar_mid_bit3", 32'(tx), 32'd0);
    frames_before = rx_frames;
    rst = 1'b1;
    #1;
    check("ar_tx_async", 32'(tx), 32'd1);
    check("ar_status_async", 32'(status_o), 32'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || status_o !== 8'h00) bad = 1'b1;
    end
    check("ar_quiet_after", 32'(bad), 32'd0);
    check("ar_no_frame", 32'(rx_frames), 32'(frames_before));
    check("final_queue", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_odev.md
Name: serial_odev

Overview:
- Byte-wide serial output peripheral on the Hummingbird I/O space. It sits directly downstream of the CPU's device decoder.
- Consumes the active-low output-device write strobe and the 8-bit databus value. Queues bytes in a small FIFO and shifts them out as 8N1 asynchronous serial, LSB first.
- Exposes a status byte for the CPU's input-device path, so firmware can poll busy, full and overrun.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal range 2..255.
- FIFO_DEPTH_LOG2, 2, log2 of FIFO depth (default depth 4); legal range 1..4.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- wr_b  input  1  active-low byte write strobe (from the device decoder output for this device).
- data_i  input  8  byte sampled on a rising edge where wr_b=0.
- stat_rd_b  input  1  active-low status read strobe (from the device decoder input select); clears overrun.
- status_o  output  8  {5'b0, ovr, full, busy}; driven continuously from registers.
- tx  output  1  serial line; idle high.

Behaviour:
- Reset (async, immediate):
  - tx=1; FIFO empty (rd/wr pointers and count = 0); ovr=0; state=IDLE; bit and baud counters=0.
  - status_o=8'h00 while rst is high and on the first edge after release.
- Reset mid-frame: the frame is aborted, tx returns high asynchronously and queued bytes are discarded.
- FIFO: depth 2^FIFO_DEPTH_LOG2, pointer wrap modulo depth, count is FIFO_DEPTH_LOG2+1 bits.
  - full = (count == depth).
  - empty = (count == 0).
- Push: on an edge with wr_b=0, data_i is written if not full, or if a pop occurs on the same edge (full with simultaneous pop accepts the push; count unchanged).
- Overrun: a push attempted while full with no same-edge pop drops the byte and sets ovr.
  - ovr is sticky; cleared on an edge with stat_rd_b=0.
  - Set and clear on the same edge: set wins (ovr=1).
- No bypass: a byte written into an empty FIFO is popped no earlier than the following edge.
- Transmit FSM, states IDLE, START, DATA, STOP; baud counter counts 0..CLKS_PER_BIT-1.
  - IDLE: tx=1. If FIFO non-empty: pop into an 8-bit shift register, go to START, clear the baud counter.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit; shift right after each bit. After bit index 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
  - An IDLE with a non-empty FIFO pops on that same edge, so back-to-back frames have no extra idle cycles.
- tx is registered (no combinational glitches).
- Latency:
  - Write at edge N into an empty FIFO in IDLE: pop at edge N+1, tx falls after edge N+1.
  - Frame length is 10*CLKS_PER_BIT cycles.
- busy = (state != IDLE) | !empty.
- Writes while the FIFO has room are always accepted, regardless of FSM state.

Decomposition:
- Shared package: FSM state encoding (2-bit enum IDLE=0, START=1, DATA=2, STOP=3) and status bit positions (BUSY=0, FULL=1, OVR=2).
- One sub-module: byte_fifo (parameterised by depth log2; push/pop, full/empty, same-edge push+pop), instantiated once.
- Baud counter, bit counter and FSM stay in the top module.

Test Plan:
- Bench parameters for all scenarios: CLKS_PER_BIT=4, FIFO_DEPTH_LOG2=2.
- Reset then idle: status_o=8'h00 and tx=1 for 50 cycles with no strobes.
- Single byte:
  - Write 8'hA5 -> tx falls one edge after the write edge.
  - Then tx = 0, then 1,0,1,0,0,1,0,1 (LSB first), then 1, each held 4 cycles (40 cycles total).
  - busy=1 throughout, 0 afterwards.
- Back-to-back frames:
  - Write 8'h01, 8'h02, 8'h03 on consecutive edges -> three contiguous 40-cycle frames with no idle gap; full never asserts.
- Overrun:
  - Write 6 bytes on consecutive edges (first is popped on the second edge) -> 5 accepted, 6th dropped.
  - status_o=8'h07 (ovr, full, busy).
  - A stat_rd_b pulse then clears ovr -> status_o=8'h03.
- Full with simultaneous pop:
  - Fill to 4 entries while a frame is in STOP, then write 8'h5A on the edge the FSM returns to IDLE and pops.
  - Required: push accepted, ovr stays 0, 8'h5A is transmitted last.
- Async reset mid-frame:
  - Assert rst during DATA bit 3 -> tx=1 immediately (before the next edge), status_o=8'h00.
  - After release, no further frame is emitted.
